// File: rtl/sobel_host_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_host_ctrl_if
//  Purpose  : Bundles the host controller's data streams and the accelerator
//             memory/control bus.
//  Modports : master - the host controller (sobel_host_ctrl)
//             slave  - the surrounding system (source, sink, accelerator)
//  Signals  : s_*          input pixel stream (valid/ready)
//             m_*          output pixel stream (valid/ready, last)
//             *_imem       input-memory write port
//             start/finish accelerator control
//             *_omem       output-memory read port (registered read)
//  Revision : 1.0 - initial release
// ============================================================================
interface sobel_host_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) ();
  logic                  s_valid_i;
  logic                  s_ready_o;
  logic [DATA_WIDTH-1:0] s_data_i;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_last_o;
  logic                  wr_en_imem_o;
  logic [ADDR_WIDTH-1:0] addr_imem_o;
  logic [DATA_WIDTH-1:0] data_imem_o;
  logic                  start_o;
  logic                  finish_i;
  logic                  rd_en_omem_o;
  logic [ADDR_WIDTH-1:0] addr_omem_o;
  logic [DATA_WIDTH-1:0] data_omem_i;

  modport master (
    input  s_valid_i, s_data_i, m_ready_i, finish_i, data_omem_i,
    output s_ready_o, m_valid_o, m_data_o, m_last_o,
           wr_en_imem_o, addr_imem_o, data_imem_o, start_o,
           rd_en_omem_o, addr_omem_o
  );

  modport slave (
    output s_valid_i, s_data_i, m_ready_i, finish_i, data_omem_i,
    input  s_ready_o, m_valid_o, m_data_o, m_last_o,
           wr_en_imem_o, addr_imem_o, data_imem_o, start_o,
           rd_en_omem_o, addr_omem_o
  );
endinterface
`default_nettype wire

// File: rtl/sobel_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_host_ctrl
//  Purpose  : Host-side controller for the sobel accelerator. Streams one
//             frame into the input memory, pulses start, waits for finish,
//             then reads the output memory back onto a valid/ready sink.
//  Ports    : clk_i        clock, rising edge
//             rst_i        asynchronous active-high reset
//             cmd_start_i  frame request, sampled in IDLE only
//             busy_o       high outside IDLE
//             done_o       one-cycle pulse after the last pixel is delivered
//             bus          sobel_host_ctrl_if.master (streams + memory bus)
//  Revision : 1.0 - initial release
// ============================================================================
module sobel_host_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PIXELS = 65536
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_start_i,
  output logic               busy_o,
  output logic               done_o,
  sobel_host_ctrl_if.master  bus
);

  // One extra bit so a full-frame count never wraps.
  localparam int                CW         = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]     c_last_idx = CW'(NUM_PIXELS - 1);
  localparam logic [CW-1:0]     c_total    = CW'(NUM_PIXELS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_KICK  = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         ld_cnt_q, ld_cnt_d;
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]         out_cnt_q, out_cnt_d;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic [DATA_WIDTH-1:0] fifo_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            fcnt_q, fcnt_d;
  logic                  inflight_q, inflight_d;

  logic                  w_pop;
  logic                  w_issue;
  logic [2:0]            w_committed;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      ld_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fcnt_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_cnt_d   = out_cnt_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fcnt_d      = fcnt_q;
    inflight_d  = 1'b0;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    w_committed = 3'(fcnt_q) + 3'(inflight_q);

    busy_o            = (state_q != S_IDLE);
    done_o            = 1'b0;
    bus.s_ready_o     = 1'b0;
    bus.wr_en_imem_o  = 1'b0;
    bus.addr_imem_o   = '0;
    bus.data_imem_o   = '0;
    bus.start_o       = 1'b0;
    bus.rd_en_omem_o  = 1'b0;
    bus.addr_omem_o   = '0;
    bus.m_valid_o     = 1'b0;
    bus.m_data_o      = '0;
    bus.m_last_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_start_i) begin
          state_d  = S_LOAD;
          ld_cnt_d = '0;
        end
      end

      S_LOAD: begin
        bus.s_ready_o    = 1'b1;
        bus.wr_en_imem_o = bus.s_valid_i;
        bus.addr_imem_o  = ld_cnt_q[ADDR_WIDTH-1:0];
        bus.data_imem_o  = bus.s_data_i;
        if (bus.s_valid_i) begin
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (ld_cnt_q == c_last_idx) begin
            state_d = S_KICK;
          end
        end
      end

      S_KICK: begin
        bus.start_o = 1'b1;
        state_d     = S_WAIT;
      end

      S_WAIT: begin
        if (bus.finish_i) begin
          state_d   = S_DRAIN;
          rd_cnt_d  = '0;
          out_cnt_d = '0;
          fcnt_d    = '0;
          wr_ptr_d  = 1'b0;
          rd_ptr_d  = 1'b0;
        end
      end

      S_DRAIN: begin
        bus.rd_en_omem_o = 1'b1;
        bus.addr_omem_o  = rd_cnt_q[ADDR_WIDTH-1:0];
        bus.m_valid_o    = (fcnt_q != 2'd0);
        bus.m_data_o     = fifo_q[rd_ptr_q];
        bus.m_last_o     = (fcnt_q != 2'd0) && (out_cnt_q == c_last_idx);
        w_pop            = (fcnt_q != 2'd0) && bus.m_ready_i;

        // Credit the slot freed by this cycle's pop so a steady ready sink
        // sees one pixel per cycle; the sum still never exceeds two slots.
        w_committed = 3'(fcnt_q) + 3'(inflight_q) - 3'(w_pop);
        w_issue     = (w_committed < 3'd2) && (rd_cnt_q < c_total);
        inflight_d  = w_issue;
        if (w_issue) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end

        // Registered memory read: data for last cycle's address is here now.
        if (inflight_q) begin
          fifo_d[wr_ptr_q] = bus.data_omem_i;
          wr_ptr_d         = ~wr_ptr_q;
        end
        if (w_pop) begin
          rd_ptr_d  = ~rd_ptr_q;
          out_cnt_d = out_cnt_q + 1'b1;
          if (out_cnt_q == c_last_idx) begin
            state_d = S_DONE;
          end
        end
        fcnt_d = fcnt_q + 2'(inflight_q) - 2'(w_pop);
      end

      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/sobel_host_ctrl.md
Name: sobel_host_ctrl

Overview:
- Host-side controller for the other end of the sobel accelerator's memory/control interface.
- Streams an input frame from a valid/ready source into the accelerator's input memory, pulses start, and waits for finish.
- Then reads the output memory back and streams it out on a valid/ready sink.
- Sits between the system datapath (DMA/camera adapter) and the sobel top-level.

Parameters:
- ADDR_WIDTH, 16: pixel address width; must match the accelerator memories.
- DATA_WIDTH, 8: pixel width.
- NUM_PIXELS, 65536: pixels per frame; must be ≤ 2**ADDR_WIDTH and ≥ 2.

Ports:
- clk_i  in  1  single clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- cmd_start_i  in  1  request one frame; sampled only in IDLE.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when the frame is fully delivered.
- s_valid_i  in  1  input pixel valid.
- s_ready_o  out  1  input pixel ready.
- s_data_i  in  DATA_WIDTH  input pixel, raster order.
- m_valid_o  out  1  output pixel valid.
- m_ready_i  in  1  output pixel ready.
- m_data_o  out  DATA_WIDTH  output pixel, raster order.
- m_last_o  out  1  marks pixel NUM_PIXELS-1; qualified by m_valid_o.
- wr_en_imem_o  out  1  input-memory write enable.
- addr_imem_o  out  ADDR_WIDTH  input-memory address.
- data_imem_o  out  DATA_WIDTH  input-memory write data.
- start_o  out  1  accelerator start pulse.
- finish_i  in  1  accelerator finish; level or pulse.
- rd_en_omem_o  out  1  claims the output-memory port for reading.
- addr_omem_o  out  ADDR_WIDTH  output-memory read address.
- data_omem_i  in  DATA_WIDTH  output-memory read data; valid 1 cycle after addr_omem_o (registered read).

Behaviour:
- Reset:
  - rst_i asserted forces state IDLE and clears all counters and the FIFO immediately, without a clock edge.
  - All outputs are 0 while in reset; a reset mid-frame abandons the frame with no done_o.
- FSM states: IDLE, LOAD, KICK, WAIT, DRAIN, DONE.
- IDLE:
  - s_ready_o=0, m_valid_o=0, rd_en_omem_o=0.
  - cmd_start_i=1 → LOAD; load counter cleared.
- LOAD:
  - s_ready_o=1.
  - Combinational write path: wr_en_imem_o = s_valid_i & s_ready_o; addr_imem_o = load counter; data_imem_o = s_data_i.
  - Each handshake increments the counter.
  - Handshake at count NUM_PIXELS-1 → KICK.
  - Outside LOAD: wr_en_imem_o=0 and addr_imem_o=0.
- KICK:
  - start_o=1 for exactly this one cycle → WAIT.
  - finish_i is ignored here and in LOAD (stale level from a prior frame).
- WAIT:
  - start_o=0; finish_i=1 → DRAIN.
  - No timeout.
- DRAIN:
  - rd_en_omem_o=1 for the whole state, so the accelerator cannot write.
  - Read pipeline: a read counter drives addr_omem_o.
    - A read issues in a cycle when (FIFO occupancy + reads in flight) < 2 and read count < NUM_PIXELS.
    - data_omem_i is captured into a 2-entry FIFO the following cycle.
  - m_valid_o = FIFO not empty; m_data_o = FIFO head.
  - A pixel pops on m_valid_o & m_ready_i.
  - m_last_o=1 when the head is pixel NUM_PIXELS-1.
  - Timing: DRAIN entered at cycle T → addr 0 at T, data captured at end of T+1, m_valid_o first high at T+2.
  - With m_ready_i held high, throughput is 1 pixel/cycle.
  - Backpressure: m_data_o/m_last_o stay stable while m_valid_o & !m_ready_i; no read issues when 2 entries are committed.
  - Pop of the last pixel → DONE.
- DONE: done_o=1 for one cycle, rd_en_omem_o=0 → IDLE.
- cmd_start_i outside IDLE: ignored, not queued.
- Counters are ADDR_WIDTH+1 bits; no wrap within a frame; all cleared on entry to LOAD/DRAIN.

Test Plan:
- NUM_PIXELS=16; feed 0x10..0x1F with no stalls; omem model returns addr^0xA5; finish_i pulsed 5 cycles after start_o; m_ready_i=1 → writes to addr 0..15 with data 0x10..0x1F; exactly one start_o pulse; m_data_o = 0xA5,0xA4,...,0xAA in order; m_last_o only on the 16th pixel; DRAIN lasts 18 cycles; one done_o pulse.
- Input bubbles (s_valid_i alternating 1/0) → wr_en_imem_o only on handshakes; addresses contiguous 0..15; KICK entered right after the 16th write.
- Output backpressure: m_ready_i low for 10 cycles after pixel 3 → m_data_o holds pixel 4 value; at most 2 reads outstanding; all 16 pixels delivered once each, in order.
- finish_i held high from reset through LOAD and KICK → no early DRAIN; WAIT exits on the first cycle after KICK; cmd_start_i pulsed in LOAD/WAIT/DRAIN → no effect, busy_o stays 1.
- rst_i asserted mid-DRAIN between clock edges → busy_o, m_valid_o, rd_en_omem_o fall to 0 asynchronously; no done_o; after release a new frame completes correctly.
